// File: rtl/pixel_write_arbiter_pkg.sv
// Shared video definitions for the pixel-write path: default widths, screen extents, pixel record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixel_write_arbiter_pkg;

   localparam int NCH_DEF  = 4;
   localparam int XW_DEF   = 10;
   localparam int YW_DEF   = 10;
   localparam int DW_DEF   = 8;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // One framebuffer write: address plus colour, x in the top bits.
   typedef struct packed {
      logic [XW_DEF-1:0] x;
      logic [YW_DEF-1:0] y;
      logic [DW_DEF-1:0] data;
   } pixel_write_t;

   // Round-robin helper: channel index after 'idx' in a ring of 'n'.
   function automatic int rr_after(input int idx, input int step, input int n);
      return (idx + step) % n;
   endfunction

endpackage

// File: rtl/pixel_write_arbiter_if.sv
// Bundle of emitter-side pixel-write channels and the merged framebuffer write port.
// Latency: n/a (wires only).
// Backpressure: none on ch_* (ch_full is advisory); out_* is a plain strobe.
interface pixel_write_arbiter_if
   import pixel_write_arbiter_pkg::*;
#(
   parameter int NCH = NCH_DEF,
   parameter int XW  = XW_DEF,
   parameter int YW  = YW_DEF,
   parameter int DW  = DW_DEF
) ();

   logic [NCH-1:0]    ch_we;
   logic [NCH*XW-1:0] ch_x;
   logic [NCH*YW-1:0] ch_y;
   logic [NCH*DW-1:0] ch_data;
   logic [NCH-1:0]    ch_full;
   logic [NCH-1:0]    ch_overflow;
   logic              out_we;
   logic [XW-1:0]     out_x;
   logic [YW-1:0]     out_y;
   logic [DW-1:0]     out_data;
   logic              idle;

   // Emitter / environment side.
   modport master (
      output ch_we, ch_x, ch_y, ch_data,
      input  ch_full, ch_overflow, out_we, out_x, out_y, out_data, idle
   );

   // Arbiter side.
   modport slave (
      input  ch_we, ch_x, ch_y, ch_data,
      output ch_full, ch_overflow, out_we, out_x, out_y, out_data, idle
   );

endinterface

// File: rtl/pixel_write_arbiter_fifo.sv
// Single-clock DEPTH-entry FIFO holding one channel's pending pixel writes.
// Latency: pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: none internally; caller must not push when full unless popping on the same edge.
module pixel_fifo #(
   parameter int W     = 28,
   parameter int DEPTH = 16
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               wdata_i,
   output logic [W-1:0]               rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   logic [W-1:0]    mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0] count_q, count_d;
   logic            full_q;

   // Occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_d = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + CNTW'(1);
      end else if (!push_i && pop_i) begin
         count_d = count_q - CNTW'(1);
      end
   end

   // Pointers, count and registered full flag; pointers wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNTW'(DEPTH));
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clock_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = full_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/pixel_write_arbiter.sv
// Merges NCH buffered pixel-write channels round-robin onto one registered framebuffer write port.
// Latency: 2 clocks from input strobe to out_we with no contention.
// Backpressure: none; a strobe into a full, unpopped channel is dropped and flagged sticky in ch_overflow.
// Optional: PIXEL_ARB_TRANSPARENT_EN discards TRANSPARENT-coloured writes on TRANSP_MASK channels.
module pixel_write_arbiter
   import pixel_write_arbiter_pkg::*;
#(
   parameter int             NCH         = NCH_DEF,
   parameter int             DEPTH       = 16,
   parameter int             XW          = XW_DEF,
   parameter int             YW          = YW_DEF,
   parameter int             DW          = DW_DEF,
   parameter logic [DW-1:0]  TRANSPARENT = '0,
   parameter logic [NCH-1:0] TRANSP_MASK = NCH'(4'b0011)
) (
   input logic                 clock,
   input logic                 reset,
   pixel_write_arbiter_if.slave bus
);

   localparam int W    = XW + YW + DW;
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CNTW = $clog2(DEPTH) + 1;

   logic [NCH-1:0]  keep, push, pop, drop, empty, full;
   logic [W-1:0]    head  [NCH];
   logic [CNTW-1:0] count [NCH];

   logic [CW-1:0]   rr_q, rr_d, grant_idx, cidx;
   logic            grant_vld;
   int              cand;

   logic [NCH-1:0]  ovf_q;
   logic            out_we_q;
   logic [XW-1:0]   out_x_q;
   logic [YW-1:0]   out_y_q;
   logic [DW-1:0]   out_data_q;

`ifndef PIXEL_ARB_TRANSPARENT_EN
   logic unused_transp;
   assign unused_transp = ^{TRANSPARENT, TRANSP_MASK};
`endif

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
`ifdef PIXEL_ARB_TRANSPARENT_EN
      assign keep[gi] = !(TRANSP_MASK[gi] && (bus.ch_data[gi*DW +: DW] == TRANSPARENT));
`else
      assign keep[gi] = 1'b1;
`endif
      // A full channel can still take a pixel on the edge its head leaves.
      assign pop[gi]  = grant_vld && (grant_idx == CW'(gi));
      assign push[gi] = bus.ch_we[gi] && keep[gi] && ((count[gi] < CNTW'(DEPTH)) || pop[gi]);
      assign drop[gi] = bus.ch_we[gi] && keep[gi] && !push[gi];

      pixel_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
         .clock_i (clock),
         .reset_i (reset),
         .push_i  (push[gi]),
         .pop_i   (pop[gi]),
         .wdata_i ({bus.ch_x[gi*XW +: XW], bus.ch_y[gi*YW +: YW], bus.ch_data[gi*DW +: DW]}),
         .rdata_o (head[gi]),
         .count_o (count[gi]),
         .full_o  (full[gi]),
         .empty_o (empty[gi])
      );
   end

   // Round-robin search starting after the last winner; pointer moves only on a grant.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = rr_q;
      cand      = 0;
      cidx      = '0;
      for (int k = 1; k <= NCH; k++) begin
         cand = rr_after(int'(rr_q), k, NCH);
         cidx = CW'(cand);
         if (!grant_vld && !empty[cidx]) begin
            grant_vld = 1'b1;
            grant_idx = cidx;
         end
      end
      rr_d = grant_vld ? grant_idx : rr_q;
   end

   // Output register, arbitration pointer and sticky overflow flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_q       <= CW'(NCH - 1);
         ovf_q      <= '0;
         out_we_q   <= 1'b0;
         out_x_q    <= '0;
         out_y_q    <= '0;
         out_data_q <= '0;
      end else begin
         rr_q     <= rr_d;
         ovf_q    <= ovf_q | drop;
         out_we_q <= grant_vld;
         if (grant_vld) begin
            {out_x_q, out_y_q, out_data_q} <= head[grant_idx];
         end
      end
   end

   assign bus.ch_full     = full;
   assign bus.ch_overflow = ovf_q;
   assign bus.out_we      = out_we_q;
   assign bus.out_x       = out_x_q;
   assign bus.out_y       = out_y_q;
   assign bus.out_data    = out_data_q;
   assign bus.idle        = (&empty) && !out_we_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model through a scoreboard.
module tb_pixel_write_arbiter;
   import pixel_write_arbiter_pkg::*;

   localparam int NCH = 4;
   localparam int DEPTH = 16;
   localparam int XW = 10;
   localparam int YW = 10;
   localparam int DW = 8;
   localparam logic [DW-1:0]  TRANSPARENT = 8'd0;
   localparam logic [NCH-1:0] TRANSP_MASK = 4'b0011;

   logic clock = 1'b0;
   logic reset = 1'b1;

   pixel_write_arbiter_if #(.NCH(NCH), .XW(XW), .YW(YW), .DW(DW)) bus ();

   pixel_write_arbiter #(
      .NCH(NCH), .DEPTH(DEPTH), .XW(XW), .YW(YW), .DW(DW),
      .TRANSPARENT(TRANSPARENT), .TRANSP_MASK(TRANSP_MASK)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   pixel_write_t   mq [NCH][$];
   int             m_ptr;
   logic [NCH-1:0] m_ovf;
   logic           exp_we;
   pixel_write_t   exp_hold;
   pixel_write_t   exp_q [$];
   bit             started = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int next_grant();
      for (int k = 1; k <= NCH; k++) begin
         if (mq[(m_ptr + k) % NCH].size() > 0) return (m_ptr + k) % NCH;
      end
      return -1;
   endfunction

   // Reference model: per-channel queues, round-robin from last winner, output shows the popped head.
   always @(posedge clock) begin
      int g;
      bit keep_px;
      pixel_write_t p;
      if (reset) begin
         for (int i = 0; i < NCH; i++) mq[i].delete();
         exp_q.delete();
         m_ptr    = NCH - 1;
         m_ovf    = '0;
         exp_we   = 1'b0;
         exp_hold = '0;
         started  = 1;
      end else begin
         g = next_grant();
         exp_we = (g >= 0);
         if (g >= 0) begin
            p = mq[g].pop_front();
            exp_q.push_back(p);
            exp_hold = p;
            m_ptr = g;
         end
         for (int i = 0; i < NCH; i++) begin
            if (bus.ch_we[i]) begin
               p.x    = bus.ch_x[i*XW +: XW];
               p.y    = bus.ch_y[i*YW +: YW];
               p.data = bus.ch_data[i*DW +: DW];
               keep_px = 1'b1;
`ifdef PIXEL_ARB_TRANSPARENT_EN
               if (TRANSP_MASK[i] && p.data == TRANSPARENT) keep_px = 1'b0;
`endif
               if (keep_px) begin
                  if (mq[i].size() < DEPTH) mq[i].push_back(p);
                  else m_ovf[i] = 1'b1;
               end
            end
         end
      end
   end

   // Monitor: compares every DUT output against the model away from the active edge.
   always @(negedge clock) begin
      pixel_write_t p;
      logic [NCH-1:0] e_full;
      bit e_idle;
      if (started) begin
         e_idle = !exp_we;
         for (int i = 0; i < NCH; i++) begin
            e_full[i] = (mq[i].size() == DEPTH);
            if (mq[i].size() != 0) e_idle = 0;
         end
         chk("out_we", 32'(bus.out_we), 32'(exp_we));
         if (bus.out_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'(bus.out_we), 32'd0);
            end else begin
               p = exp_q.pop_front();
               chk("out_x", 32'(bus.out_x), 32'(p.x));
               chk("out_y", 32'(bus.out_y), 32'(p.y));
               chk("out_data", 32'(bus.out_data), 32'(p.data));
            end
         end else begin
            chk("hold_x", 32'(bus.out_x), 32'(exp_hold.x));
            chk("hold_y", 32'(bus.out_y), 32'(exp_hold.y));
            chk("hold_data", 32'(bus.out_data), 32'(exp_hold.data));
         end
         chk("ch_full", 32'(bus.ch_full), 32'(e_full));
         chk("ch_overflow", 32'(bus.ch_overflow), 32'(m_ovf));
         chk("idle", 32'(bus.idle), 32'(e_idle));
      end
   end

   task automatic set_px(input int ch, input int x, input int y, input int d);
      bus.ch_we[ch]             = 1'b1;
      bus.ch_x[ch*XW +: XW]     = XW'(x);
      bus.ch_y[ch*YW +: YW]     = YW'(y);
      bus.ch_data[ch*DW +: DW]  = DW'(d);
   endtask

   task automatic set_rand(input logic [NCH-1:0] mask);
      for (int i = 0; i < NCH; i++) begin
         if (mask[i]) set_px(i, $urandom_range(SCREEN_W - 1), $urandom_range(SCREEN_H - 1),
                             $urandom_range(255));
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      bus.ch_we = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while (bus.idle !== 1'b1 && n < max_cycles) begin
         step();
         n++;
      end
      chk("drain_idle", 32'(bus.idle), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.ch_we   = '0;
      bus.ch_x    = '0;
      bus.ch_y    = '0;
      bus.ch_data = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state.
      chk("reset_idle", 32'(bus.idle), 32'd1);
      chk("reset_out_we", 32'(bus.out_we), 32'd0);
      chk("reset_out_x", 32'(bus.out_x), 32'd0);
      chk("reset_ovf", 32'(bus.ch_overflow), 32'd0);

      // Single pixel on ch1: visible two edges after the sampling edge, for one cycle.
      set_px(1, 100, 50, 8'hFF);
      step();
      chk("single_early", 32'(bus.out_we), 32'd0);
      step();
      chk("single_we", 32'(bus.out_we), 32'd1);
      chk("single_x", 32'(bus.out_x), 32'd100);
      chk("single_y", 32'(bus.out_y), 32'd50);
      chk("single_data", 32'(bus.out_data), 32'hFF);
      step();
      chk("single_we_off", 32'(bus.out_we), 32'd0);
      chk("single_idle", 32'(bus.idle), 32'd1);

      // Contention: two identical bursts, each served 0,1,2,3.
      do_reset();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < NCH; i++) set_px(i, 10 + i, 20 + i, 8'hA0 + i);
         step();
         for (int k = 0; k < NCH; k++) begin
            step();
            chk("contention_order", 32'(bus.out_data), 32'(8'hA0 + k));
         end
         step();
      end
      drain(50);

      // Overflow: ch2 sends a numbered sequence while the other channels saturate the port.
      do_reset();
      for (int c = 0; c < 40; c++) begin
         set_rand(4'b1011);
         if (c < 24) set_px(2, c, c, c + 1);
         step();
      end
      chk("ovf_ch2_set", 32'(bus.ch_overflow[2]), 32'd1);
      drain(400);

      // Full with simultaneous pop: fill ch3 to DEPTH without drops, then strobe on its grant.
      do_reset();
      n = 0;
      while (mq[3].size() < DEPTH && n < 300) begin
         set_rand(4'b0111);
         set_rand(4'b1000);
         step();
         n++;
      end
      chk("fill_ch3", 32'(mq[3].size()), 32'(DEPTH));
      n = 0;
      while (next_grant() != 3 && n < 20) begin
         set_rand(4'b0111);
         step();
         n++;
      end
      chk("ch3_grant_next", 32'(next_grant()), 32'd3);
      set_rand(4'b1111);
      step();
      chk("full_pop_ovf3", 32'(bus.ch_overflow[3]), 32'd0);
      chk("full_pop_full3", 32'(bus.ch_full[3]), 32'd1);
      drain(400);

      // Reset mid-burst: buffered pixels vanish, no stale writes follow.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         set_rand(4'b1111);
         step();
      end
      chk("midburst_has_data", 32'(bus.idle), 32'd0);
      do_reset();
      chk("midburst_we", 32'(bus.out_we), 32'd0);
      chk("midburst_idle", 32'(bus.idle), 32'd1);
      chk("midburst_ovf", 32'(bus.ch_overflow), 32'd0);
      repeat (20) step();

`ifdef PIXEL_ARB_TRANSPARENT_EN
      // Transparent colour on a masked channel vanishes; on an unmasked channel it is written.
      do_reset();
      set_px(0, 5, 6, 8'h00);
      step();
      step();
      chk("transp_ch0_we", 32'(bus.out_we), 32'd0);
      step();
      chk("transp_ch0_idle", 32'(bus.idle), 32'd1);
      set_px(2, 7, 8, 8'h00);
      step();
      step();
      chk("transp_ch2_we", 32'(bus.out_we), 32'd1);
      chk("transp_ch2_x", 32'(bus.out_x), 32'd7);
      chk("transp_ch2_data", 32'(bus.out_data), 32'd0);
      drain(20);
`endif

      // Random traffic with occasional resets.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(499) == 0) begin
            do_reset();
         end else begin
            for (int i = 0; i < NCH; i++) begin
               if ($urandom_range(99) < 30) begin
                  set_px(i, $urandom_range(SCREEN_W - 1), $urandom_range(SCREEN_H - 1),
                         ($urandom_range(7) == 0) ? 0 : $urandom_range(255));
               end
            end
            step();
         end
      end
      drain(400);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
